seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter REFRESH_DIV, default 12500, SHALL set the clock cycles per digit slot (1 kHz frame at 100 MHz).
REQ-003 Parameter DEAD_CYCLES, default 16, SHALL set the blanking cycles at the start of each slot; legal range is 1 <= DEAD_CYCLES < REFRESH_DIV.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 display_data  input  32  eight 4-bit glyph codes; [31:28]=AN7 ... [3:0]=AN0.
REQ-007 digit_en  input  8  per-digit enable; bit i=0 forces digit i dark.
REQ-008 dp_mask  input  8  per-digit decimal point; bit i=1 lights the DP on digit i.
REQ-009 an  output  8  active-low anode drive; bit i selects digit i.
REQ-010 seg  output  7  active-low cathodes, ordered {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  active-low decimal-point cathode.
REQ-012 frame_start  output  1  one-cycle pulse when a new frame is latched.

Function
REQ-013 Internal slot counter cnt SHALL count 0..REFRESH_DIV-1; at REFRESH_DIV-1 it SHALL wrap to 0 and digit index idx SHALL advance 0,1,...,7,0.
REQ-014 A frame-load event SHALL occur on every cycle with cnt==0 and idx==0, including the first cycle after reset release.
REQ-015 On a frame-load event, display_data SHALL be copied into a 32-bit shadow register; the shadow SHALL NOT change at any other time, so mid-frame display_data changes produce no tearing.
REQ-016 On the cycle after each frame-load event, frame_start SHALL be 1; it SHALL be 0 on all other cycles.
REQ-017 an, seg and dp SHALL be registered and SHALL reflect the cnt/idx/shadow state of the previous cycle (latency 1 cycle).
REQ-018 When cnt < DEAD_CYCLES, the registered outputs SHALL be an=8'hFF, seg=7'h7F and dp=1 (dead time, anti-ghosting).
REQ-019 When cnt >= DEAD_CYCLES and digit_en[idx]=1, an SHALL be all ones except bit idx=0, seg SHALL equal decode(shadow[4*idx+3:4*idx]), and dp SHALL equal ~dp_mask[idx].
REQ-020 When cnt >= DEAD_CYCLES and digit_en[idx]=0, the outputs SHALL be an=8'hFF, seg=7'h7F and dp=1.
REQ-021 digit_en and dp_mask SHALL be sampled live, not shadowed.
REQ-022 The glyph decode {g..a} SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=blank 1111111
REQ-023 At most one an bit SHALL be 0 on any cycle.
REQ-024 Because DEAD_CYCLES >= 1, a shadow update at cnt==0 SHALL never be visible as a partially lit digit.

Reset
REQ-025 While rst_n=0 at a clock edge, the next state SHALL be: cnt=0, idx=0, shadow=32'hFFFFFFFF, an=8'hFF, seg=7'h7F, dp=1, frame_start=0.
REQ-026 Asserting reset mid-slot or mid-frame SHALL abort the scan immediately, with no further anode activation until the REQ-025 sequence restarts.
REQ-027 The first cycle with rst_n=1 SHALL be a frame-load event per REQ-014.

Verification (REFRESH_DIV=8, DEAD_CYCLES=2)
REQ-028 Reset release with display_data=32'hFFFFFF00 and digit_en=8'hFF -> frame_start pulses one cycle later; in slot 0, an=FF for 2 cycles, then an=FE and seg=1000000 for 6 cycles; slot 1 likewise shows 0 on an=FD; slots 2-7 show seg=7F.
REQ-029 display_data=32'hCDFFFF03 -> digit 7 shows seg=1000110 (C), digit 6 shows 0100001 (d), digit 0 shows 0110000 (3); frame period is 64 cycles, with frame_start spaced 64 cycles apart.
REQ-030 display_data changes from 32'h00000012 to 32'h00000034 while idx=3 -> the remainder of the frame shows 1/2; the next frame shows 3/4.
REQ-031 digit_en=8'h01 and dp_mask=8'h01 -> only an=FE is ever asserted, with dp=0 during its lit cycles; all other slots are fully dark.
REQ-032 rst_n pulled low during slot 5, lit phase -> one cycle later an=FF, seg=7F, frame_start=0; after release, scanning restarts at idx 0 with a fresh frame load.
REQ-033 Every cycle, an SHALL be one of FF or a single-zero pattern, and dead-time cycles SHALL show seg=7F and dp=1.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - eight-digit multiplexed seven-segment scanner with frame shadowing
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 12500,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] display_data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic          frame_load;
  logic [3:0]    glyph;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  // Glyph code to active-low {g,f,e,d,c,b,a}; code F is a blank digit.
  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // A new frame is latched at the very first cycle of slot 0.
  assign frame_load = (cnt == '0) && (idx == 3'd0);
  assign glyph      = shadow[{idx, 2'b00} +: 4];

  // Next drive pattern: dark during the slot's dead time or for a disabled digit.
  always_comb begin
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if ((cnt >= CNT_DEAD) && digit_en[idx]) begin
      an_next  = ~(8'b1 << idx);
      seg_next = decode(glyph);
      dp_next  = ~dp_mask[idx];
    end
  end

  // Slot counter, digit index and frame shadow; shadow only moves on frame load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= 3'd0;
      shadow <= 32'hFFFF_FFFF;
    end else begin
      if (frame_load) begin
        shadow <= display_data;
      end
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Registered pin drive and frame pulse; reset forces everything dark at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an          <= 8'hFF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= an_next;
      seg         <= seg_next;
      dp          <= dp_next;
      frame_start <= frame_load;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

  logic        clk;
  logic        rst_n;
  logic [31:0] display_data;
  logic [7:0]  digit_en;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_vec;
  int n_err;

  seven_seg_scanner #(
    .REFRESH_DIV(8),
    .DEAD_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .display_data(display_data),
    .digit_en    (digit_en),
    .dp_mask     (dp_mask),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk ncyc cycles of a frame starting at its load edge; slot s shows an_t/seg_t/dp_t after its 2 dead cycles.
  task automatic scan_frame(input string tag,
                            input logic [7:0] an_t [8],
                            input logic [6:0] seg_t [8],
                            input logic       dp_t [8],
                            input int         chg_slot,
                            input logic [31:0] chg_data,
                            input int         ncyc);
    for (int s = 0; s < ncyc; s++) begin
      int sl;
      int c;
      sl = s / 8;
      c  = s % 8;
      if (s == chg_slot * 8) display_data = chg_data;
      tick();
      check($sformatf("%s.fs s%0d", tag, s), 32'(frame_start), 32'(s == 0));
      if (c < 2) begin
        check($sformatf("%s.an s%0d", tag, s), 32'(an), 32'h0000_00FF);
        check($sformatf("%s.seg s%0d", tag, s), 32'(seg), 32'h0000_007F);
        check($sformatf("%s.dp s%0d", tag, s), 32'(dp), 32'h1);
      end else begin
        check($sformatf("%s.an s%0d", tag, s), 32'(an), 32'(an_t[sl]));
        check($sformatf("%s.seg s%0d", tag, s), 32'(seg), 32'(seg_t[sl]));
        check($sformatf("%s.dp s%0d", tag, s), 32'(dp), 32'(dp_t[sl]));
      end
    end
  endtask

  initial begin
    logic [7:0] an_all [8];
    logic [7:0] an_d0  [8];
    logic [6:0] seg_t  [8];
    logic       dp_off [8];
    logic       dp_d0  [8];

    an_all = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    an_d0  = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    dp_off = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    dp_d0  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    n_vec = 0;
    n_err = 0;

    rst_n        = 1'b0;
    display_data = 32'hFFFF_FF00;
    digit_en     = 8'hFF;
    dp_mask      = 8'h00;

    // Reset state.
    repeat (3) tick();
    check("rst.an", 32'(an), 32'h0000_00FF);
    check("rst.seg", 32'(seg), 32'h0000_007F);
    check("rst.dp", 32'(dp), 32'h1);
    check("rst.fs", 32'(frame_start), 32'h0);

    // Release: first cycle is a frame load; digits 0,1 show "0", rest blank glyphs.
    rst_n = 1'b1;
    seg_t = '{7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    scan_frame("f0", an_all, seg_t, dp_off, -1, 32'h0, 64);

    // C d blank blank blank blank 0 3, and the frame pulse recurs 64 cycles on.
    display_data = 32'hCDFF_FF03;
    seg_t = '{7'h30, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h21, 7'h46};
    scan_frame("f1", an_all, seg_t, dp_off, -1, 32'h0, 64);

    // Mid-frame input change at idx 3 must not tear: frame still shows 1/2.
    display_data = 32'h0000_0012;
    seg_t = '{7'h24, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    scan_frame("f2", an_all, seg_t, dp_off, 3, 32'h0000_0034, 64);

    // Following frame picks up 3/4.
    seg_t = '{7'h19, 7'h30, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    scan_frame("f3", an_all, seg_t, dp_off, -1, 32'h0, 64);

    // Only digit 0 enabled, with its decimal point lit.
    display_data = 32'h0000_0012;
    digit_en     = 8'h01;
    dp_mask      = 8'h01;
    seg_t = '{7'h24, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    scan_frame("f4", an_d0, seg_t, dp_d0, -1, 32'h0, 64);

    // Run into slot 5 lit phase, then abort with reset.
    display_data = 32'h7654_3210;
    digit_en     = 8'hFF;
    dp_mask      = 8'h00;
    seg_t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    scan_frame("f5", an_all, seg_t, dp_off, -1, 32'h0, 45);
    rst_n        = 1'b0;
    display_data = 32'h89AB_CDEF;
    tick();
    check("abort.an", 32'(an), 32'h0000_00FF);
    check("abort.seg", 32'(seg), 32'h0000_007F);
    check("abort.dp", 32'(dp), 32'h1);
    check("abort.fs", 32'(frame_start), 32'h0);
    tick();
    check("abort.an2", 32'(an), 32'h0000_00FF);

    // Restart at idx 0 with a fresh load of the new data.
    rst_n = 1'b1;
    seg_t = '{7'h7F, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    scan_frame("f6", an_all, seg_t, dp_off, -1, 32'h0, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
